// File: rtl/arbitro_barramento_snooping_pkg.sv
// Shared encodings for the MSI snooping subsystem: bus messages, MSI cache
// line states and the arbiter sequencer states.
package arbitro_barramento_snooping_pkg;

  typedef enum logic [1:0] {
    invalidar    = 2'b00,
    msgReadMiss  = 2'b01,
    msgWriteMiss = 2'b10,
    semMensagem  = 2'b11
  } mensagem_t;

  typedef enum logic [1:0] {
    modificado    = 2'b00,
    compartilhado = 2'b01,
    invalido      = 2'b10
  } estado_msi_t;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    BROADCAST = 3'd1,
    SNOOP     = 3'd2,
    WRITEBACK = 3'd3,
    MEMORIA   = 3'd4,
    CONCLUI   = 3'd5
  } estado_t;

endpackage

// File: rtl/arbitro_barramento_snooping_round_robin.sv
// Combinational round-robin picker: first requester at or after ptr, with
// wrap-around, returned both one-hot and as an index.
module arbitro_round_robin #(
  parameter int N_PROC = 4
) (
  input  logic [2:0]        ptr,
  input  logic [N_PROC-1:0] req,
  output logic [N_PROC-1:0] gnt,
  output logic [2:0]        idx,
  output logic              valid
);

  // Outer loop walks offsets from the pointer so the lowest offset wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N_PROC; k++) begin
      for (int i = 0; i < N_PROC; i++) begin
        if (!valid && req[i] && (i == ((int'(ptr) + k) % N_PROC))) begin
          valid  = 1'b1;
          gnt[i] = 1'b1;
          idx    = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/arbitro_barramento_snooping.sv
// Snoop-bus arbiter and transaction sequencer: grants the bus round-robin,
// broadcasts the owner's message, samples listeners and runs the memory access.
module arbitro_barramento_snooping
  import arbitro_barramento_snooping_pkg::*;
#(
  parameter int N_PROC = 4,
  parameter int MSG_W  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_PROC-1:0]       req,
  input  logic [N_PROC*MSG_W-1:0] reqMsg,
  output logic [N_PROC-1:0]       grant,
  output logic [MSG_W-1:0]        busMsg,
  output logic [2:0]              busOwner,
  input  logic [N_PROC-1:0]       snoopWB,
  input  logic [N_PROC-1:0]       snoopAbort,
  output logic                    memRead,
  output logic                    memWrite,
  input  logic                    memReady,
  output logic [N_PROC-1:0]       done
);

  estado_t           state;
  logic [2:0]        ptr;
  logic [MSG_W-1:0]  msgLatch;
  logic              abortSeen;
  logic [N_PROC-1:0] rrGnt;
  logic [2:0]        rrIdx;
  logic              rrValid;
  logic [MSG_W-1:0]  msgSel;
  logic              wbAny;
  logic              abortAny;
  logic              semMemoria;

  arbitro_round_robin #(.N_PROC(N_PROC)) u_rr (
    .ptr   (ptr),
    .req   (req),
    .gnt   (rrGnt),
    .idx   (rrIdx),
    .valid (rrValid)
  );

  always_comb begin
    msgSel = '0;
    for (int i = 0; i < N_PROC; i++) begin
      if (rrGnt[i]) msgSel = reqMsg[i*MSG_W +: MSG_W];
    end
  end

  // The owner snoops its own broadcast too, so its flags are masked out.
  assign wbAny      = |(snoopWB & ~grant);
  assign abortAny   = |(snoopAbort & ~grant);
  assign semMemoria = (msgLatch == MSG_W'(invalidar)) ||
                      (msgLatch == MSG_W'(semMensagem));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= OCIOSO;
      ptr       <= '0;
      grant     <= '0;
      busMsg    <= MSG_W'(semMensagem);
      busOwner  <= '0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      done      <= '0;
      msgLatch  <= MSG_W'(semMensagem);
      abortSeen <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        OCIOSO: begin
          if (rrValid) begin
            grant    <= rrGnt;
            busOwner <= rrIdx;
            msgLatch <= msgSel;
            busMsg   <= msgSel;
            state    <= BROADCAST;
          end
        end
        BROADCAST: begin
          busMsg <= MSG_W'(semMensagem);
          state  <= SNOOP;
        end
        SNOOP: begin
          abortSeen <= abortAny;
          if (semMemoria) begin
            done  <= grant;
            state <= CONCLUI;
          end else if (wbAny) begin
            memWrite <= 1'b1;
            state    <= WRITEBACK;
          end else begin
            memRead <= 1'b1;
            state   <= MEMORIA;
          end
        end
        WRITEBACK: begin
          if (memReady) begin
            memWrite <= 1'b0;
            // An aborting listener supplies the line, so memory is not read.
            if (abortSeen) begin
              done  <= grant;
              state <= CONCLUI;
            end else begin
              memRead <= 1'b1;
              state   <= MEMORIA;
            end
          end
        end
        MEMORIA: begin
          if (memReady) begin
            memRead <= 1'b0;
            done    <= grant;
            state   <= CONCLUI;
          end
        end
        CONCLUI: begin
          grant <= '0;
          ptr   <= (busOwner == 3'(N_PROC - 1)) ? 3'd0 : busOwner + 3'd1;
          state <= OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_barramento_snooping.sv
// Bench for arbitro_barramento_snooping: a cycle-by-cycle vector table plus
// hand-written fairness and mid-transaction reset sequences.
module tb_arbitro_barramento_snooping;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [7:0] reqMsg;
  logic [3:0] grant;
  logic [1:0] busMsg;
  logic [2:0] busOwner;
  logic [3:0] snoopWB;
  logic [3:0] snoopAbort;
  logic       memRead;
  logic       memWrite;
  logic       memReady;
  logic [3:0] done;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [7:0] msg;
    logic [3:0] wb;
    logic [3:0] ab;
    logic       rdy;
    logic [3:0] eGrant;
    logic [1:0] eBus;
    logic [2:0] eOwner;
    logic       eRd;
    logic       eWr;
    logic [3:0] eDone;
  } vec_t;

  vec_t vecs[$];

  arbitro_barramento_snooping #(.N_PROC(4), .MSG_W(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .reqMsg     (reqMsg),
    .grant      (grant),
    .busMsg     (busMsg),
    .busOwner   (busOwner),
    .snoopWB    (snoopWB),
    .snoopAbort (snoopAbort),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memReady   (memReady),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic addVec(input logic rst, input logic [3:0] rq, input logic [7:0] msg,
                        input logic [3:0] wb, input logic [3:0] ab, input logic rdy,
                        input logic [3:0] eGrant, input logic [1:0] eBus,
                        input logic [2:0] eOwner, input logic eRd, input logic eWr,
                        input logic [3:0] eDone);
    vec_t v;
    v.rst = rst; v.req = rq; v.msg = msg; v.wb = wb; v.ab = ab; v.rdy = rdy;
    v.eGrant = eGrant; v.eBus = eBus; v.eOwner = eOwner;
    v.eRd = eRd; v.eWr = eWr; v.eDone = eDone;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset      = v.rst;
    req        = v.req;
    reqMsg     = v.msg;
    snoopWB    = v.wb;
    snoopAbort = v.ab;
    memReady   = v.rdy;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [14:0] actual,
                             input logic [14:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [14:0] packOut();
    return {grant, busMsg, busOwner, memRead, memWrite, done};
  endfunction

  logic [3:0] expOrder [5];
  int         cnt;
  logic       doneSeen;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b0; req = '0; reqMsg = '0; snoopWB = '0; snoopAbort = '0; memReady = 1'b0;

    // Reset held with all requesting, then transaction of requester 0.
    addVec(0, 4'b1111, 8'h00, 0, 0, 0, 4'b0000, 2'b11, 0, 0, 0, 4'b0000);
    addVec(0, 4'b1111, 8'h00, 0, 0, 0, 4'b0000, 2'b11, 0, 0, 0, 4'b0000);
    addVec(1, 4'b1111, 8'h00, 0, 0, 0, 4'b0001, 2'b00, 0, 0, 0, 4'b0000);
    addVec(1, 4'b1111, 8'h00, 0, 0, 0, 4'b0001, 2'b11, 0, 0, 0, 4'b0000);
    addVec(1, 4'b1111, 8'h00, 0, 0, 0, 4'b0001, 2'b11, 0, 0, 0, 4'b0001);
    addVec(1, 4'b0000, 8'h00, 0, 0, 0, 4'b0000, 2'b11, 0, 0, 0, 4'b0000);
    // Invalidar from requester 2; listener WB ignored.
    addVec(1, 4'b0100, 8'b11_00_10_01, 0, 0, 0, 4'b0100, 2'b00, 2, 0, 0, 4'b0000);
    addVec(1, 4'b0100, 8'b11_00_10_01, 0, 0, 0, 4'b0100, 2'b11, 2, 0, 0, 4'b0000);
    addVec(1, 4'b0100, 8'b11_00_10_01, 4'b1000, 0, 0, 4'b0100, 2'b11, 2, 0, 0, 4'b0100);
    addVec(1, 4'b0000, 8'b11_00_10_01, 0, 0, 0, 4'b0000, 2'b11, 2, 0, 0, 4'b0000);
    // Clean read miss from requester 1; stray memReady in BROADCAST ignored.
    addVec(1, 4'b0010, 8'b00_00_01_00, 0, 0, 0, 4'b0010, 2'b01, 1, 0, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_01_00, 0, 0, 1, 4'b0010, 2'b11, 1, 0, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_01_00, 0, 0, 0, 4'b0010, 2'b11, 1, 1, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_01_00, 0, 0, 0, 4'b0010, 2'b11, 1, 1, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_01_00, 0, 0, 0, 4'b0010, 2'b11, 1, 1, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_01_00, 0, 0, 0, 4'b0010, 2'b11, 1, 1, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_01_00, 0, 0, 1, 4'b0010, 2'b11, 1, 0, 0, 4'b0010);
    addVec(1, 4'b0000, 8'b00_00_01_00, 0, 0, 0, 4'b0000, 2'b11, 1, 0, 0, 4'b0000);
    // Owned read miss from requester 0; listener 3 writes back and aborts.
    addVec(1, 4'b0001, 8'b00_00_00_01, 0, 0, 0, 4'b0001, 2'b01, 0, 0, 0, 4'b0000);
    addVec(1, 4'b0001, 8'b00_00_00_01, 0, 0, 0, 4'b0001, 2'b11, 0, 0, 0, 4'b0000);
    addVec(1, 4'b0001, 8'b00_00_00_01, 4'b1000, 4'b1000, 0, 4'b0001, 2'b11, 0, 0, 1, 4'b0000);
    addVec(1, 4'b0001, 8'b00_00_00_01, 0, 0, 0, 4'b0001, 2'b11, 0, 0, 1, 4'b0000);
    addVec(1, 4'b0001, 8'b00_00_00_01, 0, 0, 1, 4'b0001, 2'b11, 0, 0, 0, 4'b0001);
    addVec(1, 4'b0000, 8'b00_00_00_01, 0, 0, 0, 4'b0000, 2'b11, 0, 0, 0, 4'b0000);
    // Write miss from requester 3; listener 1 writes back without abort.
    addVec(1, 4'b1000, 8'b10_00_00_00, 0, 0, 0, 4'b1000, 2'b10, 3, 0, 0, 4'b0000);
    addVec(1, 4'b1000, 8'b10_00_00_00, 0, 0, 0, 4'b1000, 2'b11, 3, 0, 0, 4'b0000);
    addVec(1, 4'b1000, 8'b10_00_00_00, 4'b0010, 0, 0, 4'b1000, 2'b11, 3, 0, 1, 4'b0000);
    addVec(1, 4'b1000, 8'b10_00_00_00, 0, 0, 1, 4'b1000, 2'b11, 3, 1, 0, 4'b0000);
    addVec(1, 4'b1000, 8'b10_00_00_00, 0, 0, 0, 4'b1000, 2'b11, 3, 1, 0, 4'b0000);
    addVec(1, 4'b1000, 8'b10_00_00_00, 0, 0, 1, 4'b1000, 2'b11, 3, 0, 0, 4'b1000);
    addVec(1, 4'b0000, 8'b10_00_00_00, 0, 0, 0, 4'b0000, 2'b11, 3, 0, 0, 4'b0000);
    // Write miss from requester 2 with only its own flags set: masked.
    addVec(1, 4'b0100, 8'b00_10_00_00, 0, 0, 0, 4'b0100, 2'b10, 2, 0, 0, 4'b0000);
    addVec(1, 4'b0100, 8'b00_10_00_00, 0, 0, 0, 4'b0100, 2'b11, 2, 0, 0, 4'b0000);
    addVec(1, 4'b0100, 8'b00_10_00_00, 4'b0100, 4'b0100, 0, 4'b0100, 2'b11, 2, 1, 0, 4'b0000);
    addVec(1, 4'b0100, 8'b00_10_00_00, 0, 0, 1, 4'b0100, 2'b11, 2, 0, 0, 4'b0100);
    addVec(1, 4'b0000, 8'b00_10_00_00, 0, 0, 0, 4'b0000, 2'b11, 2, 0, 0, 4'b0000);
    // Pointer at 3: requesters 0 and 1, wrap picks 0 (semMensagem); owner drops
    // req mid-transaction; requester 1 arrives during CONCLUI.
    addVec(1, 4'b0011, 8'b00_00_00_11, 0, 0, 0, 4'b0001, 2'b11, 0, 0, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_00_11, 0, 0, 0, 4'b0001, 2'b11, 0, 0, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_00_11, 4'b1000, 0, 0, 4'b0001, 2'b11, 0, 0, 0, 4'b0001);
    addVec(1, 4'b0010, 8'b00_00_00_11, 0, 0, 0, 4'b0000, 2'b11, 0, 0, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_00_11, 0, 0, 0, 4'b0010, 2'b00, 1, 0, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_00_11, 0, 0, 0, 4'b0010, 2'b11, 1, 0, 0, 4'b0000);
    addVec(1, 4'b0010, 8'b00_00_00_11, 0, 0, 0, 4'b0010, 2'b11, 1, 0, 0, 4'b0010);
    addVec(1, 4'b0000, 8'b00_00_00_11, 0, 0, 0, 4'b0000, 2'b11, 1, 0, 0, 4'b0000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), packOut(),
                  {vecs[i].eGrant, vecs[i].eBus, vecs[i].eOwner,
                   vecs[i].eRd, vecs[i].eWr, vecs[i].eDone});
    end

    // Fairness with all four requesting continuously (invalidar each time).
    expOrder[0] = 4'b0001; expOrder[1] = 4'b0010; expOrder[2] = 4'b0100;
    expOrder[3] = 4'b1000; expOrder[4] = 4'b0001;
    reset = 1'b0; req = 4'b1111; reqMsg = 8'h00; snoopWB = '0; snoopAbort = '0; memReady = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cnt = 0;
      while (grant == 4'b0000 && cnt < 20) begin tick(); cnt++; end
      checkOutput($sformatf("fairGrant%0d", k), {11'b0, grant}, {11'b0, expOrder[k]});
      cnt = 0;
      while (grant != 4'b0000 && cnt < 20) begin tick(); cnt++; end
      checkOutput($sformatf("fairRelease%0d", k), 15'(cnt < 20), 15'd1);
    end

    // Reset while in MEMORIA aborts with no done pulse.
    req = 4'b0010; reqMsg = 8'b00_00_01_00;
    cnt = 0;
    while (!memRead && cnt < 20) begin tick(); cnt++; end
    checkOutput("reachMemoria", 15'(memRead), 15'd1);
    reset = 1'b0;
    tick();
    checkOutput("midReset", packOut(), {4'b0000, 2'b11, 3'd0, 1'b0, 1'b0, 4'b0000});
    reset = 1'b1; req = 4'b0000; memReady = 1'b1;
    doneSeen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      memReady = 1'b0;
      doneSeen = doneSeen | (|done) | (|grant) | memRead | memWrite;
    end
    checkOutput("noDoneAfterReset", 15'(doneSeen), 15'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/arbitro_barramento_snooping.md
Name: arbitro_barramento_snooping

Overview:
- Snoop-bus arbiter and transaction sequencer for the MSI snooping-coherence subsystem.
- Shares one broadcast bus among N_PROC cache controllers. Each controller hosts one MSI state machine instance, acting as the atuante (local) side.
- Grants the bus round-robin, broadcasts the winner's bus message to all listeners, and samples their reaction flags (writeBack, abortAccessMemory).
- Sequences the resulting memory read or write-back, then signals completion to the requester.

Parameters:
- N_PROC, 4, number of cache controllers sharing the bus (2..8).
- MSG_W, 2, bus message width. Encoding: 00 invalidar, 01 readMiss, 10 writeMiss, 11 semMensagem.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  N_PROC  per-controller bus request; held high until the matching done pulse.
- reqMsg  in  N_PROC*MSG_W  per-controller message; slice i = bits [2i+1:2i]; stable while req[i] is high.
- grant  out  N_PROC  one-hot; current bus owner; high from grant to done.
- busMsg  out  MSG_W  broadcast message; 11 when no transaction is in the BROADCAST state.
- busOwner  out  3  index of the current owner, so the owner can ignore its own broadcast.
- snoopWB  in  N_PROC  listeners' writeBack flags; sampled in the SNOOP state only.
- snoopAbort  in  N_PROC  listeners' abortAccessMemory flags; sampled in the SNOOP state only.
- memRead  out  1  memory read request; level signal.
- memWrite  out  1  memory write-back request; level signal.
- memReady  in  1  memory completion; one-cycle pulse.
- done  out  N_PROC  one-hot, one-cycle completion pulse to the owner.

Behaviour:
- Reset (reset==0 at a clock edge): FSM goes to OCIOSO, round-robin pointer = 0. Outputs: grant=0, busMsg=11, busOwner=0, memRead=0, memWrite=0, done=0.
- Reset mid-transaction aborts everything immediately; no done pulse is issued.
- FSM states: OCIOSO, BROADCAST, SNOOP, WRITEBACK, MEMORIA, CONCLUI.
- OCIOSO:
  - If any req is high, pick the first requester at or after the pointer, in increasing index order with wrap-around.
  - Register grant and busOwner, latch that requester's reqMsg, go to BROADCAST.
  - No requests: stay in OCIOSO.
- BROADCAST (exactly 1 cycle): drive busMsg = latched message, go to SNOOP.
- SNOOP (exactly 1 cycle): OR snoopWB and snoopAbort over all listeners; the owner's bits are masked. Next state:
  - latched message 00 (invalidar): CONCLUI; no memory access.
  - 11 (semMensagem): CONCLUI; protocol no-op, tolerated.
  - 01 or 10 with any WB: WRITEBACK.
  - 01 or 10 with no WB: MEMORIA.
- WRITEBACK: assert memWrite until memReady.
  - If abort was seen, the listener supplies the data: go to CONCLUI.
  - Otherwise go to MEMORIA.
- MEMORIA: assert memRead until memReady, then go to CONCLUI.
- CONCLUI (1 cycle):
  - Pulse done for the owner and clear grant.
  - Advance the pointer to owner+1 mod N_PROC.
  - Return to OCIOSO.
- memReady outside WRITEBACK/MEMORIA is ignored. memRead and memWrite are never high together.
- Minimum latency from grant to done: 3 cycles (invalidar). Read miss with no writeback: 4 cycles + memory wait.
- A requester dropping req while granted does not cancel the transaction; done is still pulsed.
- A new request arriving in CONCLUI is considered in the next OCIOSO cycle, giving one idle cycle between transactions.

Decomposition:
- Shared package: message encodings (invalidar, msgReadMiss, msgWriteMiss, semMensagem), MSI state encodings, FSM state encoding. The existing MSI state machine uses the same message encodings.
- Sub-module: arbitro_round_robin (combinational: pointer + req vector -> one-hot grant + index).
- The FSM and the latches stay in the top module.

Test Plan:
- Reset: reset=0 for 2 cycles with req=1111 -> grant=0000, busMsg=11, memRead=0, memWrite=0, done=0. After release, grant=0001 on the next edge.
- Invalidar: req[2]=1, msg=00 -> grant=0100, then busMsg=00 for exactly 1 cycle. done[2] pulses 3 cycles after grant; no memRead/memWrite.
- Clean read miss: req[1]=1, msg=01, snoop flags 0 -> memRead held; memReady pulsed 5 cycles later -> done[1] the next cycle; memWrite never asserted.
- Owned read miss: msg=01, listener 3 sets snoopWB=1 and snoopAbort=1 -> memWrite only. After memReady, done pulses; memRead is never asserted.
- Write-back without abort: msg=10, snoopWB=1, snoopAbort=0 -> memWrite, then memRead, then done. Also check that the owner's own WB bit set alone is masked, giving memRead only.
- Fairness: req=1111 held continuously -> grants in order 0001, 0010, 0100, 1000, 0001. Also drive reset=0 during MEMORIA -> OCIOSO with no done pulse.
